// File: rtl/osd_info_arbiter.sv
// Round-robin arbiter sharing the single OSD info channel between status
// sources, with a post-reset quiet window and a minimum display hold.
module osd_info_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int HOLD_CYCLES   = 16_000_000,
    parameter int STARTUP_DELAY = 4_000_000,
    parameter int CNT_BITS      = $clog2(((HOLD_CYCLES > STARTUP_DELAY) ?
                                          HOLD_CYCLES : STARTUP_DELAY) + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC*8-1:0]       src_code,
    output logic [7:0]                 info,
    output logic                       info_req,
    output logic [$clog2(NUM_SRC)-1:0] grant_src,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_SRC);
    localparam logic [CNT_BITS-1:0] HOLD_LOAD  = CNT_BITS'(HOLD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] START_LOAD = CNT_BITS'(STARTUP_DELAY - 1);
    localparam logic [IW-1:0]       LAST_SRC   = IW'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        S_STARTUP,
        S_IDLE,
        S_HOLD
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_d;
    logic [NUM_SRC-1:0]  pend;
    logic [7:0]          code [NUM_SRC];
    logic                grant;
    logic [IW-1:0]       sel;
    logic                rr_hit;
    logic [IW-1:0]       rr_sel;

    // First pending source after the last granted one, wrapping around.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        rr_hit = 1'b0;
        rr_sel = grant_src;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx  = (int'(grant_src) + k) % NUM_SRC;
            cand = IW'(idx);
            if (!rr_hit && pend[cand]) begin
                rr_hit = 1'b1;
                rr_sel = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        grant   = 1'b0;
        sel     = rr_sel;
        unique case (state)
            S_STARTUP: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_BITS'(1);
                end
            end
            S_IDLE: begin
                if (rr_hit) begin
                    grant = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else if (pend[grant_src]) begin
                    // The source on screen may replace its own message.
                    grant = 1'b1;
                    sel   = grant_src;
                end else begin
                    cnt_d = cnt - CNT_BITS'(1);
                end
            end
            default: begin
                state_d = S_STARTUP;
            end
        endcase
        if (grant) begin
            cnt_d   = HOLD_LOAD;
            state_d = S_HOLD;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic       pend_q;
        logic [7:0] code_q;
        logic       post_ok;

        assign post_ok = (state != S_STARTUP) && src_req[i] &&
                         (src_code[8*i +: 8] != 8'd0);

        // A post on the grant edge wins over the clear.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                pend_q <= 1'b0;
                code_q <= 8'd0;
            end else if (post_ok) begin
                pend_q <= 1'b1;
                code_q <= src_code[8*i +: 8];
            end else if (grant && (sel == IW'(i))) begin
                pend_q <= 1'b0;
            end
        end

        assign pend[i] = pend_q;
        assign code[i] = code_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_STARTUP;
            cnt       <= START_LOAD;
            info      <= 8'd0;
            info_req  <= 1'b0;
            grant_src <= LAST_SRC;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            info_req <= grant;
            if (grant) begin
                info      <= code[sel];
                grant_src <= sel;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
